// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: instruction record, field widths and FSM states.
package issue_scheduler_pkg;

  localparam int REG_IDX_W = 5;
  localparam int OPCODE_W  = 7;
  localparam int IMM_W     = 16;

  typedef struct packed {
    logic                 format;
    logic                 is_branch;
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_IDX_W-1:0] prim;
    logic [IMM_W-1:0]     sec;
  } instr_t;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } fsm_e;

endpackage

// File: rtl/sched_fifo.sv
// In-order instruction queue with push/pop/flush; exposes current and next occupancy.
module sched_fifo
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  instr_t           data_i,
  output instr_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  instr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_next_o = count_q;
    if (flush_i) begin
      count_next_o = '0;
    end else if (push_i && !pop_i) begin
      count_next_o = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_next_o = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_next_o;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_i && !reset_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/issue_scheduler.sv
// Queues parsed instructions, blocks on register hazards and unresolved branches,
// and issues one instruction per cycle over a valid/ready handshake.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SKID       = 2,
  parameter int NUM_REGS   = 32
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        instructionFormat_i,
  input  logic        isBranch_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  primOperand_i,
  input  logic [15:0] secOperand_i,
  output logic        stall_o,
  output logic        overflow_o,
  output logic        exec_valid_o,
  input  logic        exec_ready_i,
  output logic        exec_format_o,
  output logic        exec_isBranch_o,
  output logic [6:0]  exec_opcode_o,
  output logic [4:0]  exec_primOperand_o,
  output logic [15:0] exec_secOperand_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_reg_i,
  input  logic        branch_resolved_i,
  input  logic        branch_taken_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  instr_t              in_instr;
  instr_t              head;
  instr_t              exec_q;
  logic                exec_valid_q;
  logic                stall_q;
  logic                overflow_q;
  fsm_e                fsm_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    fifo_count_next;
  logic                fifo_empty;
  logic                fifo_full;
  logic                head_ok;
  logic                load;
  logic                push;
  logic                flush;

  assign in_instr = '{format:    instructionFormat_i,
                      is_branch: isBranch_i,
                      opcode:    opcode_i,
                      prim:      primOperand_i,
                      sec:       secOperand_i};

  assign flush   = (fsm_q == BR_WAIT) && branch_resolved_i && branch_taken_i;
  assign head_ok = !fifo_empty && (fsm_q == RUN) && !busy_q[head.prim] &&
                   (head.format || !busy_q[head.sec[REG_IDX_W-1:0]]);
  assign load    = head_ok && (!exec_valid_q || exec_ready_i);
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign push    = enable_i && (!fifo_full || load) && !flush;

  sched_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .pop_i        (load),
    .flush_i      (flush),
    .data_i       (in_instr),
    .head_o       (head),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_reg_i] = 1'b0;
    if (load && !head.is_branch) busy_d[head.prim] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      exec_q       <= '0;
      exec_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= '0;
      fsm_q        <= RUN;
    end else begin
      busy_q  <= busy_d;
      stall_q <= (fifo_count_next >= CNT_W'(FIFO_DEPTH - SKID));
      if (enable_i && fifo_full && !load) overflow_q <= 1'b1;
      if (load) begin
        exec_q       <= head;
        exec_valid_q <= 1'b1;
      end else if (exec_ready_i) begin
        exec_valid_q <= 1'b0;
      end
      case (fsm_q)
        RUN:     if (load && head.is_branch) fsm_q <= BR_WAIT;
        BR_WAIT: if (branch_resolved_i) fsm_q <= RUN;
        default: fsm_q <= RUN;
      endcase
    end
  end

  assign stall_o            = stall_q;
  assign overflow_o         = overflow_q;
  assign exec_valid_o       = exec_valid_q;
  assign exec_format_o      = exec_q.format;
  assign exec_isBranch_o    = exec_q.is_branch;
  assign exec_opcode_o      = exec_q.opcode;
  assign exec_primOperand_o = exec_q.prim;
  assign exec_secOperand_o  = exec_q.sec;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: latency, hazards, branches, back-pressure and reset.
module tb_issue_scheduler;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        instructionFormat_i;
  logic        isBranch_i;
  logic [6:0]  opcode_i;
  logic [4:0]  primOperand_i;
  logic [15:0] secOperand_i;
  logic        stall_o;
  logic        overflow_o;
  logic        exec_valid_o;
  logic        exec_ready_i;
  logic        exec_format_o;
  logic        exec_isBranch_o;
  logic [6:0]  exec_opcode_o;
  logic [4:0]  exec_primOperand_o;
  logic [15:0] exec_secOperand_o;
  logic        wb_valid_i;
  logic [4:0]  wb_reg_i;
  logic        branch_resolved_i;
  logic        branch_taken_i;

  int checks = 0;
  int errors = 0;

  issue_scheduler dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .enable_i           (enable_i),
    .instructionFormat_i(instructionFormat_i),
    .isBranch_i         (isBranch_i),
    .opcode_i           (opcode_i),
    .primOperand_i      (primOperand_i),
    .secOperand_i       (secOperand_i),
    .stall_o            (stall_o),
    .overflow_o         (overflow_o),
    .exec_valid_o       (exec_valid_o),
    .exec_ready_i       (exec_ready_i),
    .exec_format_o      (exec_format_o),
    .exec_isBranch_o    (exec_isBranch_o),
    .exec_opcode_o      (exec_opcode_o),
    .exec_primOperand_o (exec_primOperand_o),
    .exec_secOperand_o  (exec_secOperand_o),
    .wb_valid_i         (wb_valid_i),
    .wb_reg_i           (wb_reg_i),
    .branch_resolved_i  (branch_resolved_i),
    .branch_taken_i     (branch_taken_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_inputs();
    enable_i = 0; instructionFormat_i = 0; isBranch_i = 0; opcode_i = '0;
    primOperand_i = '0; secOperand_i = '0; exec_ready_i = 0; wb_valid_i = 0;
    wb_reg_i = '0; branch_resolved_i = 0; branch_taken_i = 0;
  endtask

  task automatic drive(input logic fmt, input logic br, input logic [6:0] op,
                       input logic [4:0] p, input logic [15:0] s);
    enable_i = 1; instructionFormat_i = fmt; isBranch_i = br;
    opcode_i = op; primOperand_i = p; secOperand_i = s;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1;
    tick();
    tick();
    reset_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", exec_valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow_o); end
    checks++; if (exec_opcode_o !== 7'd0) begin errors++; $display("FAIL reset_opcode got %0d exp 0", exec_opcode_o); end
    checks++; if (dut.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", dut.fifo_count); end
    checks++; if (dut.busy_q !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", dut.busy_q); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exec_ready_i = 1;
    drive(1, 0, 7'd5, 5'd1, 16'h00AA);
    tick();
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_latency got %0b exp 0", exec_valid_o); end
    drive(1, 0, 7'd5, 5'd2, 16'h00BB);
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_primOperand_o !== 5'd1 || exec_opcode_o !== 7'd5)
      begin errors++; $display("FAIL b2b_first got v=%0b p=%0d op=%0d exp v=1 p=1 op=5", exec_valid_o, exec_primOperand_o, exec_opcode_o); end
    checks++; if (exec_secOperand_o !== 16'h00AA) begin errors++; $display("FAIL b2b_sec got %h exp 00aa", exec_secOperand_o); end
    drive(1, 0, 7'd5, 5'd3, 16'h00CC);
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_primOperand_o !== 5'd2)
      begin errors++; $display("FAIL b2b_second got v=%0b p=%0d exp v=1 p=2", exec_valid_o, exec_primOperand_o); end
    enable_i = 0;
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_primOperand_o !== 5'd3)
      begin errors++; $display("FAIL b2b_third got v=%0b p=%0d exp v=1 p=3", exec_valid_o, exec_primOperand_o); end
    tick();
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", exec_valid_o); end
    checks++; if (dut.busy_q !== 32'h0000_000E) begin errors++; $display("FAIL b2b_busy got %h exp 0000000e", dut.busy_q); end
  endtask

  task automatic test_raw_hazard();
    do_reset();
    exec_ready_i = 1;
    drive(1, 0, 7'd1, 5'd4, 16'h0000);
    tick();
    drive(0, 0, 7'd2, 5'd5, 16'h0004);
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_opcode_o !== 7'd1)
      begin errors++; $display("FAIL raw_producer got v=%0b op=%0d exp v=1 op=1", exec_valid_o, exec_opcode_o); end
    enable_i = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL raw_hold%0d got %0b exp 0", i, exec_valid_o); end
    end
    wb_valid_i = 1; wb_reg_i = 5'd4;
    tick();
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got %0b exp 0", exec_valid_o); end
    wb_valid_i = 0;
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_opcode_o !== 7'd2 || exec_primOperand_o !== 5'd5)
      begin errors++; $display("FAIL raw_consumer got v=%0b op=%0d p=%0d exp v=1 op=2 p=5", exec_valid_o, exec_opcode_o, exec_primOperand_o); end
  endtask

  task automatic test_branch(input logic taken);
    do_reset();
    exec_ready_i = 1;
    drive(1, 1, 7'd99, 5'd9, 16'h0010);
    tick();
    drive(1, 0, 7'd10, 5'd1, 16'h0000);
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_isBranch_o !== 1'b1)
      begin errors++; $display("FAIL br_issue_t%0b got v=%0b br=%0b exp v=1 br=1", taken, exec_valid_o, exec_isBranch_o); end
    drive(1, 0, 7'd11, 5'd2, 16'h0000);
    tick();
    enable_i = 0;
    tick();
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL br_wait_t%0b got %0b exp 0", taken, exec_valid_o); end
    checks++; if (dut.busy_q[9] !== 1'b0) begin errors++; $display("FAIL br_nobusy_t%0b got %0b exp 0", taken, dut.busy_q[9]); end
    branch_resolved_i = 1; branch_taken_i = taken;
    if (taken) drive(1, 0, 7'd12, 5'd3, 16'h0000);
    tick();
    idle_inputs();
    exec_ready_i = 1;
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL br_resolve_t%0b got %0b exp 0", taken, exec_valid_o); end
    if (taken) begin
      checks++; if (dut.fifo_count !== 3'd0) begin errors++; $display("FAIL br_flush_count got %0d exp 0", dut.fifo_count); end
      for (int i = 0; i < 2; i++) begin
        tick();
        checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL br_flushed%0d got %0b exp 0", i, exec_valid_o); end
      end
    end else begin
      checks++; if (dut.fifo_count !== 3'd2) begin errors++; $display("FAIL br_keep_count got %0d exp 2", dut.fifo_count); end
      tick();
      checks++; if (exec_valid_o !== 1'b1 || exec_opcode_o !== 7'd10)
        begin errors++; $display("FAIL br_nt_first got v=%0b op=%0d exp v=1 op=10", exec_valid_o, exec_opcode_o); end
      tick();
      checks++; if (exec_valid_o !== 1'b1 || exec_opcode_o !== 7'd11)
        begin errors++; $display("FAIL br_nt_second got v=%0b op=%0d exp v=1 op=11", exec_valid_o, exec_opcode_o); end
    end
  endtask

  task automatic test_back_pressure();
    logic [2:0] exp_count [1:6];
    logic       exp_stall [1:6];
    logic       exp_valid [1:6];
    logic       exp_ovf   [1:6];
    exp_count = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_stall = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ovf   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, 7'(20 + k), 5'(k), 16'(k));
      tick();
      checks++; if (dut.fifo_count !== exp_count[k]) begin errors++; $display("FAIL bp_count%0d got %0d exp %0d", k, dut.fifo_count, exp_count[k]); end
      checks++; if (stall_o !== exp_stall[k]) begin errors++; $display("FAIL bp_stall%0d got %0b exp %0b", k, stall_o, exp_stall[k]); end
      checks++; if (exec_valid_o !== exp_valid[k]) begin errors++; $display("FAIL bp_valid%0d got %0b exp %0b", k, exec_valid_o, exp_valid[k]); end
      checks++; if (overflow_o !== exp_ovf[k]) begin errors++; $display("FAIL bp_ovf%0d got %0b exp %0b", k, overflow_o, exp_ovf[k]); end
      if (k >= 2) begin
        checks++; if (exec_opcode_o !== 7'd21 || exec_secOperand_o !== 16'd1)
          begin errors++; $display("FAIL bp_stable%0d got op=%0d sec=%0d exp op=21 sec=1", k, exec_opcode_o, exec_secOperand_o); end
      end
    end
    enable_i = 0;
    exec_ready_i = 1;
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_opcode_o !== 7'd22)
      begin errors++; $display("FAIL bp_resume got v=%0b op=%0d exp v=1 op=22", exec_valid_o, exec_opcode_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got %0b exp 1", overflow_o); end
    checks++; if (dut.fifo_count !== 3'd3) begin errors++; $display("FAIL bp_drain_count got %0d exp 3", dut.fifo_count); end
  endtask

  task automatic test_same_cycle_wb();
    do_reset();
    exec_ready_i = 1;
    drive(1, 0, 7'd7, 5'd7, 16'h0000);
    tick();
    enable_i = 0;
    wb_valid_i = 1; wb_reg_i = 5'd7;
    tick();
    checks++; if (exec_valid_o !== 1'b1 || exec_primOperand_o !== 5'd7)
      begin errors++; $display("FAIL wb_issue got v=%0b p=%0d exp v=1 p=7", exec_valid_o, exec_primOperand_o); end
    checks++; if (dut.busy_q[7] !== 1'b1) begin errors++; $display("FAIL wb_set_wins got %0b exp 1", dut.busy_q[7]); end
    tick();
    wb_valid_i = 0;
    checks++; if (dut.busy_q[7] !== 1'b0) begin errors++; $display("FAIL wb_clear got %0b exp 0", dut.busy_q[7]); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, 7'(40 + k), 5'(k), 16'h0000);
      tick();
    end
    checks++; if (overflow_o !== 1'b1 || dut.busy_q[1] !== 1'b1)
      begin errors++; $display("FAIL mr_pre got ovf=%0b busy1=%0b exp 1 1", overflow_o, dut.busy_q[1]); end
    reset_i = 1;
    tick();
    checks++; if (exec_valid_o !== 1'b0 || stall_o !== 1'b0 || overflow_o !== 1'b0)
      begin errors++; $display("FAIL mr_outputs got v=%0b s=%0b o=%0b exp 0 0 0", exec_valid_o, stall_o, overflow_o); end
    checks++; if (exec_opcode_o !== 7'd0 || exec_primOperand_o !== 5'd0)
      begin errors++; $display("FAIL mr_fields got op=%0d p=%0d exp 0 0", exec_opcode_o, exec_primOperand_o); end
    checks++; if (dut.busy_q !== 32'd0 || dut.fifo_count !== 3'd0)
      begin errors++; $display("FAIL mr_state got busy=%h cnt=%0d exp 0 0", dut.busy_q, dut.fifo_count); end
    reset_i = 0;
    idle_inputs();
    exec_ready_i = 1;
    tick();
    tick();
    checks++; if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL mr_discard got %0b exp 0", exec_valid_o); end
  endtask

  initial begin
    idle_inputs();
    reset_i = 1;
    test_reset();
    test_back_to_back();
    test_raw_hazard();
    test_branch(1'b1);
    test_branch(1'b0);
    test_back_pressure();
    test_same_cycle_wb();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
